product_accumulator: RTL and testbench
======================================

# product_accumulator

Sequential accumulation stage directly downstream of the 8×8 combinational multiplier. It consumes a stream of 16-bit products over a valid/ready handshake and sums a programmed number of them into a wide accumulator. It then presents the total, with a sticky overflow flag, on a second valid/ready handshake. It also registers the multiplier's combinational output, so no multiplier path reaches the next consumer unregistered.

## Interface
Parameters:
- ACC_W, default 24: accumulator width. Must be ≥ 16. The default holds 255 × 0xFE01 without overflow.
- CNT_W, default 8: width of the term counter and of `len`.

Ports:
- clk  input  1  rising-edge clock; the only clock.
- rst_n  input  1  reset; asynchronous, active-low.
- start  input  1  begin a new accumulation. Sampled only in IDLE.
- len  input  CNT_W  number of products to accumulate. Sampled with `start`.
- busy  output  1  high whenever state ≠ IDLE.
- prod_valid  input  1  `product` is valid.
- prod_ready  output  1  high only in RUN.
- product  input  16  unsigned product from the multiplier.
- acc_valid  output  1  high only in DONE.
- acc_ready  input  1  downstream accepts the result.
- acc_sum  output  ACC_W  accumulated sum.
- acc_ovf  output  1  sticky carry-out of the accumulator for the current run.

## Operation
- States: IDLE, RUN, DONE. Encoding is free.
- IDLE:
  - `start`=1 and `len`≠0: clear acc_sum and acc_ovf to 0, load cnt←len, go to RUN.
  - `start`=1 and `len`=0: clear acc_sum and acc_ovf to 0, go directly to DONE.
  - `start`=0: stay in IDLE. acc_sum and acc_ovf keep the last result.
- RUN, on each accept (prod_valid & prod_ready):
  - acc_sum ← acc_sum + zero-extended product. The result wraps modulo 2^ACC_W.
  - acc_ovf ← acc_ovf | carry-out.
  - cnt ← cnt − 1.
  - If cnt = 1 at the accept, go to DONE.
  - Without an accept, all registers hold.
- DONE: acc_valid=1, and acc_sum/acc_ovf are stable. On acc_ready=1, go to IDLE.
- `start` is ignored in RUN and DONE. `len` changes outside the start cycle have no effect.
- `product` is unsigned only. No sign handling.

## Timing
- Reset values: state=IDLE, acc_sum=0, acc_ovf=0, cnt=0, busy=0, prod_ready=0, acc_valid=0. Reset takes effect immediately and asynchronously.
- Reset mid-RUN or mid-DONE: the partial sum is discarded, and outputs return to their reset values with no further handshake.
- start → RUN: busy and prod_ready rise in the cycle after the `start` edge.
- Throughput: one product per cycle while prod_valid is held high. A run of N terms with no gaps occupies N RUN cycles.
- Result latency: acc_valid rises in the cycle after the edge that accepted the last product. acc_sum already includes that product.
- Backpressure:
  - acc_valid, acc_sum and acc_ovf hold until the edge where acc_ready=1.
  - prod_ready stays 0 throughout DONE.
  - acc_ready has no effect outside DONE.
- Turnaround: DONE → IDLE takes one edge. The next `start` is accepted at the earliest on the following edge, giving a minimum of one IDLE cycle between runs.
- All outputs are driven from registers or directly from the state. There is no combinational path from product to acc_sum.

## Test plan
- **Basic sum.** Reset, then start with len=3 and feed 0x0001, 0x00FF, 0xFE01 on consecutive cycles. Required: acc_sum=0xFF01, acc_ovf=0, and acc_valid high exactly 1 cycle after the third accept.
- **Backpressure and gaps.** Start with len=2. Drop prod_valid for 3 cycles between the two products 0x1234 and 0x0101. Hold acc_ready=0 for 5 cycles. Required:
  - acc_sum=0x1335 stable during the hold;
  - prod_ready=0 throughout DONE;
  - IDLE follows the acc_ready edge.
- **Zero length.** Start with len=0. Required: DONE on the next cycle with acc_sum=0, acc_ovf=0, and prod_ready never asserted.
- **Full-scale, defaults.** Start with len=255 and feed 0xFE01 every cycle. Required: acc_sum=0xFD02FF and acc_ovf=0.
- **Overflow.** With ACC_W=16, start with len=2 and feed 0xFE01 twice. Required: acc_sum=0xFC02 and acc_ovf=1. A following run with len=1 and 0x0005 gives acc_sum=0x0005 and acc_ovf=0.
- **Start while busy, and reset mid-run.**
  - Start with len=4 and accept 2 products.
  - Pulse start with len=1. Required: ignored, and 2 further products are still needed.
  - Assert rst_n=0 mid-clock. Required: all outputs reach their reset values at once, without waiting for a clock edge.

Source files
------------

// File: rtl/product_accumulator.sv
// Accumulates a programmed number of 16-bit multiplier products into a wide sum,
// then presents the total and a sticky carry-out on a valid/ready result port.
module product_accumulator #(
  parameter int unsigned ACC_W = 24,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  output logic             busy,
  input  logic             prod_valid,
  output logic             prod_ready,
  input  logic [15:0]      product,
  output logic             acc_valid,
  input  logic             acc_ready,
  output logic [ACC_W-1:0] acc_sum,
  output logic             acc_ovf
);

  localparam int unsigned EXT_W = ACC_W + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             accept_c;
  logic             load_c;
  logic [EXT_W-1:0] sum_ext_c;

  assign accept_c  = prod_valid & prod_ready;
  assign load_c    = (state == IDLE) & start;
  assign sum_ext_c = {1'b0, acc_sum} + EXT_W'(product);

  // State register; status outputs are registered copies of the next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      busy       <= 1'b0;
      prod_ready <= 1'b0;
      acc_valid  <= 1'b0;
    end else begin
      state      <= state_nxt;
      busy       <= (state_nxt != IDLE);
      prod_ready <= (state_nxt == RUN);
      acc_valid  <= (state_nxt == DONE);
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = (len == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (accept_c && (cnt == CNT_W'(1))) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (acc_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Accumulator datapath; registers hold whenever no load and no accept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_sum <= '0;
      acc_ovf <= 1'b0;
      cnt     <= '0;
    end else if (load_c) begin
      acc_sum <= '0;
      acc_ovf <= 1'b0;
      cnt     <= len;
    end else if (accept_c) begin
      acc_sum <= sum_ext_c[ACC_W-1:0];
      acc_ovf <= acc_ovf | sum_ext_c[ACC_W];
      cnt     <= cnt - CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_product_accumulator.sv
// Bench for product_accumulator: a default-width and a 16-bit instance share stimulus,
// and a scoreboard of expected totals is checked when each result is presented.
module tb_product_accumulator;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [7:0]  len;
  logic        prod_valid;
  logic [15:0] product;
  logic        acc_ready;

  logic        busy_a, prod_ready_a, acc_valid_a, acc_ovf_a;
  logic [23:0] acc_sum_a;
  logic        busy_b, prod_ready_b, acc_valid_b, acc_ovf_b;
  logic [15:0] acc_sum_b;

  always #5 clk = ~clk;

  product_accumulator u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len), .busy(busy_a),
    .prod_valid(prod_valid), .prod_ready(prod_ready_a), .product(product),
    .acc_valid(acc_valid_a), .acc_ready(acc_ready), .acc_sum(acc_sum_a), .acc_ovf(acc_ovf_a)
  );

  product_accumulator #(.ACC_W(16), .CNT_W(8)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len), .busy(busy_b),
    .prod_valid(prod_valid), .prod_ready(prod_ready_b), .product(product),
    .acc_valid(acc_valid_b), .acc_ready(acc_ready), .acc_sum(acc_sum_b), .acc_ovf(acc_ovf_b)
  );

  typedef struct packed {
    logic [23:0] sum_a;
    logic        ovf_a;
    logic [15:0] sum_b;
    logic        ovf_b;
  } exp_t;

  exp_t        sb_q[$];
  logic [15:0] terms_q[$];
  int          checks = 0;
  int          errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, busy_a, 0);
    check({tag, "_prod_ready"}, prod_ready_a, 0);
    check({tag, "_acc_valid"}, acc_valid_a, 0);
    check({tag, "_acc_sum"}, acc_sum_a, 0);
    check({tag, "_acc_ovf"}, acc_ovf_a, 0);
    check({tag, "_busy16"}, busy_b, 0);
    check({tag, "_acc_sum16"}, acc_sum_b, 0);
    check({tag, "_acc_ovf16"}, acc_ovf_b, 0);
  endtask

  // Model the expected totals for terms_q, push them, then issue start
  task automatic begin_run(input int n);
    exp_t        e;
    logic [24:0] s;
    logic [16:0] t;
    e = '0;
    foreach (terms_q[i]) begin
      s = {1'b0, e.sum_a} + 25'(terms_q[i]);
      e.sum_a = s[23:0];
      e.ovf_a = e.ovf_a | s[24];
      t = {1'b0, e.sum_b} + 17'(terms_q[i]);
      e.sum_b = t[15:0];
      e.ovf_b = e.ovf_b | t[16];
    end
    sb_q.push_back(e);
    start = 1'b1;
    len   = 8'(n);
    tick;
    start = 1'b0;
    len   = 8'hA5;
    check("busy_after_start", busy_a, 1);
    check("busy16_after_start", busy_b, 1);
    if (n == 0) begin
      check("zero_len_valid", acc_valid_a, 1);
      check("zero_len_prod_ready", prod_ready_a, 0);
    end else begin
      check("run_prod_ready", prod_ready_a, 1);
      check("run_acc_valid", acc_valid_a, 0);
    end
  endtask

  task automatic feed(input logic [15:0] p);
    int budget;
    bit acc;
    product    = p;
    prod_valid = 1'b1;
    budget     = 0;
    acc        = prod_ready_a;
    tick;
    while (!acc && budget < 20) begin
      acc = prod_ready_a;
      tick;
      budget++;
    end
    if (!acc) check("feed_timeout", 0, 1);
    prod_valid = 1'b0;
    product    = 16'hDEAD;
  endtask

  // Called right after the last accept: result must already be valid
  task automatic finish_run(input int hold);
    exp_t e;
    int   budget;
    budget = 0;
    while (!acc_valid_a && budget < 20) begin
      tick;
      budget++;
    end
    check("acc_valid_latency", budget, 0);
    if (sb_q.size() == 0) begin
      check("scoreboard_empty", 0, 1);
      return;
    end
    e = sb_q.pop_front();
    for (int i = 0; i <= hold; i++) begin
      check("acc_sum", acc_sum_a, e.sum_a);
      check("acc_ovf", acc_ovf_a, e.ovf_a);
      check("acc_sum16", acc_sum_b, e.sum_b);
      check("acc_ovf16", acc_ovf_b, e.ovf_b);
      check("done_valid", acc_valid_a, 1);
      check("done_prod_ready", prod_ready_a, 0);
      acc_ready = (i == hold);
      tick;
    end
    acc_ready = 1'b0;
    check("idle_busy", busy_a, 0);
    check("idle_valid", acc_valid_a, 0);
    check("idle_busy16", busy_b, 0);
    check("idle_sum_kept", acc_sum_a, e.sum_a);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; len = '0; prod_valid = 1'b0; product = '0; acc_ready = 1'b0;
    tick;
    check_reset_outputs("reset");
    rst_n = 1'b1;
    tick;

    // Basic sum
    terms_q = '{16'h0001, 16'h00FF, 16'hFE01};
    begin_run(3);
    foreach (terms_q[i]) feed(terms_q[i]);
    finish_run(0);
    check("basic_sum_const", acc_sum_a, 32'h00FF01);

    // Gaps between products, then held result
    terms_q = '{16'h1234, 16'h0101};
    begin_run(2);
    feed(16'h1234);
    for (int i = 0; i < 3; i++) begin
      check("gap_prod_ready", prod_ready_a, 1);
      check("gap_acc_valid", acc_valid_a, 0);
      tick;
    end
    feed(16'h0101);
    finish_run(5);
    check("gap_sum_const", acc_sum_a, 32'h1335);

    // Zero length
    terms_q = {};
    begin_run(0);
    finish_run(1);

    // Full scale: 255 x 0xFE01
    terms_q = {};
    for (int i = 0; i < 255; i++) terms_q.push_back(16'hFE01);
    begin_run(255);
    foreach (terms_q[i]) feed(terms_q[i]);
    finish_run(0);
    check("full_scale_const", acc_sum_a, 32'hFD02FF);

    // Overflow on the 16-bit instance, then a clean follow-up run
    terms_q = '{16'hFE01, 16'hFE01};
    begin_run(2);
    foreach (terms_q[i]) feed(terms_q[i]);
    finish_run(0);
    check("ovf16_sum_const", acc_sum_b, 32'hFC02);
    check("ovf16_flag_const", acc_ovf_b, 1);
    terms_q = '{16'h0005};
    begin_run(1);
    feed(16'h0005);
    finish_run(0);

    // Start while busy is ignored
    terms_q = '{16'h0010, 16'h0020, 16'h0030, 16'h0040};
    begin_run(4);
    feed(16'h0010);
    feed(16'h0020);
    start = 1'b1;
    len   = 8'd1;
    tick;
    start = 1'b0;
    check("busy_start_ignored", prod_ready_a, 1);
    check("busy_start_no_valid", acc_valid_a, 0);
    feed(16'h0030);
    check("third_of_four_running", prod_ready_a, 1);
    check("third_of_four_no_valid", acc_valid_a, 0);
    feed(16'h0040);
    finish_run(0);

    // Asynchronous reset mid-run
    terms_q = '{16'h0007, 16'h0008, 16'h0009};
    begin_run(3);
    feed(16'h0007);
    feed(16'h0008);
    #3 rst_n = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    sb_q.delete();
    #2 rst_n = 1'b1;
    tick;
    check("post_reset_busy", busy_a, 0);

    // Recovery after reset
    terms_q = '{16'h0ABC};
    begin_run(1);
    feed(16'h0ABC);
    finish_run(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
